// File: rtl/vec_stream_arbiter.sv
// rtl/vec_stream_arbiter.sv - round-robin merge of instruction/load streams into one tagged command stream with store budgeting
// Optional store-completion watchdog: define VSA_STORE_TIMEOUT_EN.
module vec_stream_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] instr_recv_msg,
    input  logic        instr_recv_val,
    output logic        instr_recv_rdy,
    input  logic [63:0] load_recv_msg,
    input  logic        load_recv_val,
    output logic        load_recv_rdy,
    output logic [65:0] cmd_send_msg,
    output logic        cmd_send_val,
    input  logic        cmd_send_rdy,
    input  logic        store_resp_val,
    output logic [3:0]  stores_pending,
    output logic        idle,
    output logic        timeout_err
);

    localparam logic [1:0] T_INSTR = 2'b00;
    localparam logic [1:0] T_STORE = 2'b01;
    localparam logic [1:0] T_LOAD  = 2'b10;

    logic       or_can_load;
    logic       instr_is_store;
    logic       held_store;
    logic [4:0] in_flight;
    logic       instr_elig;
    logic       load_elig;
    logic       grant_instr;
    logic       grant_load;
    logic       instr_acc;
    logic       load_acc;
    logic       store_issue;
    logic       store_done;
    logic       last_grant_load;

    always_comb begin
        or_can_load    = !cmd_send_val || cmd_send_rdy;
        instr_is_store = (instr_recv_msg[31:27] == 5'b00001);
        held_store     = cmd_send_val && (cmd_send_msg[65:64] == T_STORE);
        // A store sitting in the output register already counts against the budget.
        in_flight      = {1'b0, stores_pending} + {4'b0, held_store};
        instr_elig     = instr_recv_val && (!instr_is_store || (in_flight < 5'(MAX_OUTSTANDING)));
        load_elig      = load_recv_val;
        grant_instr    = instr_elig && (!load_elig || last_grant_load);
        grant_load     = load_elig && (!instr_elig || !last_grant_load);
        instr_recv_rdy = !wb_rst_i && or_can_load && grant_instr;
        load_recv_rdy  = !wb_rst_i && or_can_load && grant_load;
        instr_acc      = instr_recv_val && instr_recv_rdy;
        load_acc       = load_recv_val && load_recv_rdy;
        store_issue    = held_store && cmd_send_rdy;
        store_done     = store_resp_val && (stores_pending != 4'd0);
        idle           = !cmd_send_val && (stores_pending == 4'd0);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            cmd_send_val    <= 1'b0;
            cmd_send_msg    <= '0;
            last_grant_load <= 1'b1;
            stores_pending  <= 4'd0;
        end else begin
            if (or_can_load) begin
                if (instr_acc) begin
                    cmd_send_val <= 1'b1;
                    cmd_send_msg <= {(instr_is_store ? T_STORE : T_INSTR), 32'h0, instr_recv_msg};
                end else if (load_acc) begin
                    cmd_send_val <= 1'b1;
                    cmd_send_msg <= {T_LOAD, load_recv_msg};
                end else begin
                    cmd_send_val <= 1'b0;
                end
            end
            if (instr_acc) begin
                last_grant_load <= 1'b0;
            end else if (load_acc) begin
                last_grant_load <= 1'b1;
            end
            case ({store_issue, store_done})
                2'b10:   stores_pending <= stores_pending + 4'd1;
                2'b01:   stores_pending <= stores_pending - 4'd1;
                default: stores_pending <= stores_pending;
            endcase
        end
    end

`ifdef VSA_STORE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if ((stores_pending == 4'd0) || store_resp_val) begin
            wd_cnt <= '0;
        end else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    // Watchdog absent: the comparison folds to a constant 0.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_vec_stream_arbiter.sv
// tb/tb_vec_stream_arbiter.sv - directed scoreboard bench for vec_stream_arbiter
module tb_vec_stream_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [31:0] instr_recv_msg;
    logic        instr_recv_val;
    logic        instr_recv_rdy;
    logic [63:0] load_recv_msg;
    logic        load_recv_val;
    logic        load_recv_rdy;
    logic [65:0] cmd_send_msg;
    logic        cmd_send_val;
    logic        cmd_send_rdy;
    logic        store_resp_val;
    logic [3:0]  stores_pending;
    logic        idle;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;
    logic [65:0] sb[$];

    always #5 wb_clk_i = ~wb_clk_i;

    vec_stream_arbiter #(.MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .instr_recv_msg (instr_recv_msg),
        .instr_recv_val (instr_recv_val),
        .instr_recv_rdy (instr_recv_rdy),
        .load_recv_msg  (load_recv_msg),
        .load_recv_val  (load_recv_val),
        .load_recv_rdy  (load_recv_rdy),
        .cmd_send_msg   (cmd_send_msg),
        .cmd_send_val   (cmd_send_val),
        .cmd_send_rdy   (cmd_send_rdy),
        .store_resp_val (store_resp_val),
        .stores_pending (stores_pending),
        .idle           (idle),
        .timeout_err    (timeout_err)
    );

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on output handshake, push on input handshake.
    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            sb.delete();
        end else begin
            if (cmd_send_val && cmd_send_rdy) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_cmd", cmd_send_msg, 66'h0);
                end else begin
                    chk("sb_cmd", cmd_send_msg, sb.pop_front());
                end
            end
            if (instr_recv_val && instr_recv_rdy)
                sb.push_back({(instr_recv_msg[31:27] == 5'b00001) ? 2'b01 : 2'b00, 32'h0, instr_recv_msg});
            if (load_recv_val && load_recv_rdy)
                sb.push_back({2'b10, load_recv_msg});
        end
    end

    task automatic drive_edge();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic do_reset();
        drive_edge();
        wb_rst_i = 1'b1;
        instr_recv_val = 1'b0;
        load_recv_val = 1'b0;
        store_resp_val = 1'b0;
        cmd_send_rdy = 1'b1;
        drive_edge();
        drive_edge();
        wb_rst_i = 1'b0;
    endtask

    initial begin
        int acc;
        wb_rst_i = 1'b1;
        instr_recv_msg = 32'h0;
        instr_recv_val = 1'b1;
        load_recv_msg = 64'h0;
        load_recv_val = 1'b1;
        cmd_send_rdy = 1'b1;
        store_resp_val = 1'b0;
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("rst_cmd_val", cmd_send_val, 0);
        chk("rst_cmd_msg", cmd_send_msg, 0);
        chk("rst_pending", stores_pending, 0);
        chk("rst_idle", idle, 1);
        chk("rst_instr_rdy", instr_recv_rdy, 0);
        chk("rst_load_rdy", load_recv_rdy, 0);
        chk("rst_timeout", timeout_err, 0);

        // Single instruction
        drive_edge();
        wb_rst_i = 1'b0;
        load_recv_val = 1'b0;
        instr_recv_msg = 32'h12345678;
        instr_recv_val = 1'b1;
        @(negedge wb_clk_i);
        chk("single_rdy", instr_recv_rdy, 1);
        drive_edge();
        instr_recv_val = 1'b0;
        @(negedge wb_clk_i);
        chk("single_val", cmd_send_val, 1);
        chk("single_msg", cmd_send_msg, {2'b00, 32'h0, 32'h12345678});
        chk("single_idle_busy", idle, 0);
        @(negedge wb_clk_i);
        chk("single_idle_after", idle, 1);

        // Alternation from reset: instr first
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i != 0) drive_edge();
            instr_recv_val = 1'b1;
            load_recv_val = 1'b1;
            instr_recv_msg = 32'h10000000 | i;
            load_recv_msg = {32'(i), 32'hA0000000 | i};
            @(negedge wb_clk_i);
            chk($sformatf("rr_instr_rdy_%0d", i), instr_recv_rdy, (i % 2) == 0);
            chk($sformatf("rr_load_rdy_%0d", i), load_recv_rdy, (i % 2) == 1);
            if (i != 0) chk($sformatf("rr_val_%0d", i), cmd_send_val, 1);
        end
        drive_edge();
        instr_recv_val = 1'b0;
        load_recv_val = 1'b0;

        // Store budget
        do_reset();
        acc = 0;
        instr_recv_val = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) drive_edge();
            instr_recv_msg = 32'h08000000 | acc;
            @(negedge wb_clk_i);
            if (instr_recv_rdy) acc++;
        end
        chk("store_issued", acc, 4);
        chk("store_pending4", stores_pending, 4);
        chk("store_blocked_rdy", instr_recv_rdy, 0);
        drive_edge();
        load_recv_msg = 64'h0000_0007_CAFEF00D;
        load_recv_val = 1'b1;
        @(negedge wb_clk_i);
        chk("store_load_passes", load_recv_rdy, 1);
        chk("store_still_blocked", instr_recv_rdy, 0);
        drive_edge();
        load_recv_val = 1'b0;
        store_resp_val = 1'b1;
        @(negedge wb_clk_i);
        chk("store_resp_cycle_rdy", instr_recv_rdy, 0);
        drive_edge();
        store_resp_val = 1'b0;
        @(negedge wb_clk_i);
        chk("store_fifth_rdy", instr_recv_rdy, 1);
        drive_edge();
        instr_recv_val = 1'b0;
        @(negedge wb_clk_i);
        chk("store_fifth_msg", cmd_send_msg, {2'b01, 32'h0, 32'h08000004});
        @(negedge wb_clk_i);
        chk("store_pending_back4", stores_pending, 4);

        // Response coinciding with a store handshake
        drive_edge();
        store_resp_val = 1'b1;
        drive_edge();
        store_resp_val = 1'b0;
        instr_recv_msg = 32'h08000055;
        instr_recv_val = 1'b1;
        @(negedge wb_clk_i);
        chk("coinc_pending3", stores_pending, 3);
        chk("coinc_rdy", instr_recv_rdy, 1);
        drive_edge();
        instr_recv_val = 1'b0;
        store_resp_val = 1'b1;
        drive_edge();
        store_resp_val = 1'b0;
        @(negedge wb_clk_i);
        chk("coinc_pending_same", stores_pending, 3);
        drive_edge();
        store_resp_val = 1'b1;
        drive_edge();
        drive_edge();
        drive_edge();
        @(negedge wb_clk_i);
        chk("resp_at_zero", stores_pending, 0);
        drive_edge();
        store_resp_val = 1'b0;
        @(negedge wb_clk_i);
        chk("resp_at_zero_hold", stores_pending, 0);
        chk("resp_idle", idle, 1);

        // Backpressure stall
        drive_edge();
        cmd_send_rdy = 1'b0;
        load_recv_msg = 64'h00000003DEADBEEF;
        load_recv_val = 1'b1;
        @(negedge wb_clk_i);
        chk("stall_load_rdy", load_recv_rdy, 1);
        drive_edge();
        load_recv_msg = 64'h1111111122222222;
        instr_recv_msg = 32'h00000001;
        instr_recv_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) drive_edge();
            @(negedge wb_clk_i);
            chk($sformatf("stall_msg_%0d", i), cmd_send_msg, {2'b10, 64'h00000003DEADBEEF});
            chk($sformatf("stall_val_%0d", i), cmd_send_val, 1);
            chk($sformatf("stall_irdy_%0d", i), instr_recv_rdy, 0);
            chk($sformatf("stall_lrdy_%0d", i), load_recv_rdy, 0);
        end
        drive_edge();
        instr_recv_val = 1'b0;
        load_recv_val = 1'b0;
        cmd_send_rdy = 1'b1;
        @(negedge wb_clk_i);
        chk("stall_release_val", cmd_send_val, 1);
        @(negedge wb_clk_i);
        chk("stall_drained", cmd_send_val, 0);

        // Reset mid-operation
        drive_edge();
        cmd_send_rdy = 1'b0;
        instr_recv_msg = 32'h08000001;
        instr_recv_val = 1'b1;
        drive_edge();
        instr_recv_val = 1'b0;
        wb_rst_i = 1'b1;
        drive_edge();
        wb_rst_i = 1'b0;
        cmd_send_rdy = 1'b1;
        @(negedge wb_clk_i);
        chk("midrst_val", cmd_send_val, 0);
        chk("midrst_msg", cmd_send_msg, 0);
        chk("midrst_idle", idle, 1);

`ifdef VSA_STORE_TIMEOUT_EN
        drive_edge();
        instr_recv_msg = 32'h08000099;
        instr_recv_val = 1'b1;
        drive_edge();
        instr_recv_val = 1'b0;
        for (int i = 0; i < 3; i++) drive_edge();
        @(negedge wb_clk_i);
        chk("wd_pending", stores_pending, 1);
        chk("wd_not_yet", timeout_err, 0);
        for (int i = 0; i < 10; i++) drive_edge();
        @(negedge wb_clk_i);
        chk("wd_fired", timeout_err, 1);
        drive_edge();
        store_resp_val = 1'b1;
        drive_edge();
        store_resp_val = 1'b0;
        drive_edge();
        @(negedge wb_clk_i);
        chk("wd_sticky", timeout_err, 1);
        chk("wd_pending_zero", stores_pending, 0);
        do_reset();
        @(negedge wb_clk_i);
        chk("wd_reset_clear", timeout_err, 0);
`else
        for (int i = 0; i < 20; i++) drive_edge();
        @(negedge wb_clk_i);
        chk("no_wd_timeout", timeout_err, 0);
`endif

        drive_edge();
        @(negedge wb_clk_i);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
